// File: rtl/wb_pkg.sv
// Shared widths, request type and source encoding for the register writeback arbiter.
package wb_pkg;

    localparam int unsigned WB_DATA_W = 8;
    localparam int unsigned WB_ADDR_W = 4;

    // Cycles a load may wait at the queue head before it takes the port from the ALU.
    localparam int unsigned LQ_AGE_LIMIT = 2;
    localparam int unsigned LQ_AGE_W     = 2;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SrcNone,
        SrcAlu,
        SrcQueue,
        SrcBypass
    } wb_src_e;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-result queue: circular buffer with explicit occupancy, head always visible.
module wb_load_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU and load results onto one registered register-file write port and keeps
// a pending-write scoreboard. Define WRITEBACK_FWD_EN for two write-port forwarding taps.
// rst_n asserts asynchronously; its release is expected to be synchronous to clk.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W   = WB_DATA_W,
    parameter int unsigned ADDR_W   = WB_ADDR_W,
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef WRITEBACK_FWD_EN
    input  logic [ADDR_W-1:0]    fwd_addr0,
    input  logic [ADDR_W-1:0]    fwd_addr1,
    output logic                 fwd_hit0,
    output logic                 fwd_hit1,
    output logic [DATA_W-1:0]    fwd_data0,
    output logic [DATA_W-1:0]    fwd_data1,
`endif
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_addr,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_addr,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 write_enable,
    output logic [ADDR_W-1:0]    write_addr,
    output logic [DATA_W-1:0]    write_data
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(LQ_DEPTH + 1);
    localparam int unsigned NREGS   = 2**ADDR_W;

    logic               lq_push, lq_pop, lq_full, lq_empty;
    logic [ENTRY_W-1:0] lq_head;
    logic [CNT_W-1:0]   lq_count;

    logic [LQ_AGE_W-1:0] age_q, age_d;
    logic                force_ld;
    wb_src_e             src;

    logic              write_enable_q, wr_en_d;
    logic [ADDR_W-1:0] write_addr_q, wr_addr_d;
    logic [DATA_W-1:0] write_data_q, wr_data_d;
    logic [NREGS-1:0]  busy_q, busy_d;

    wb_load_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LQ_DEPTH)
    ) u_load_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lq_push),
        .push_data ({ld_addr, ld_data}),
        .pop       (lq_pop),
        .full      (lq_full),
        .empty     (lq_empty),
        .head      (lq_head),
        .count     (lq_count)
    );

    // The head takes the port unconditionally when the queue is full or has aged out; both
    // ready signals are built from registered state only.
    always_comb begin
        force_ld  = !lq_empty && (lq_full || (age_q >= LQ_AGE_W'(LQ_AGE_LIMIT)));
        alu_ready = !force_ld;
        ld_ready  = (lq_count != CNT_W'(LQ_DEPTH));
    end

    always_comb begin
        src = SrcNone;
        if (force_ld) begin
            src = SrcQueue;
        end else if (alu_valid) begin
            src = SrcAlu;
        end else if (!lq_empty) begin
            src = SrcQueue;
        end else if (ld_valid) begin
            // Empty queue and idle ALU: skip the queue so a load sees ALU latency.
            src = SrcBypass;
        end
        lq_pop  = (src == SrcQueue);
        lq_push = ld_valid && ld_ready && (src != SrcBypass);
    end

    always_comb begin
        age_d = age_q;
        if (lq_pop || lq_empty) begin
            age_d = '0;
        end else if (age_q < LQ_AGE_W'(LQ_AGE_LIMIT)) begin
            age_d = age_q + LQ_AGE_W'(1);
        end
    end

    always_comb begin
        wr_en_d   = (src != SrcNone);
        wr_addr_d = write_addr_q;
        wr_data_d = write_data_q;
        case (src)
            SrcAlu: begin
                wr_addr_d = alu_addr;
                wr_data_d = alu_data;
            end
            SrcQueue: begin
                wr_addr_d = lq_head[ENTRY_W-1 -: ADDR_W];
                wr_data_d = lq_head[DATA_W-1:0];
            end
            SrcBypass: begin
                wr_addr_d = ld_addr;
                wr_data_d = ld_data;
            end
            default: ;
        endcase
    end

    // Clear before set so a re-issue in the retiring cycle keeps the bit pending.
    always_comb begin
        busy_d = busy_q;
        if (write_enable_q) begin
            busy_d[write_addr_q] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q          <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            busy_q         <= '0;
        end else begin
            age_q          <= age_d;
            write_enable_q <= wr_en_d;
            write_addr_q   <= wr_addr_d;
            write_data_q   <= wr_data_d;
            busy_q         <= busy_d;
        end
    end

    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign busy         = busy_q;

`ifdef WRITEBACK_FWD_EN
    assign fwd_hit0  = write_enable_q && (write_addr_q == fwd_addr0);
    assign fwd_hit1  = write_enable_q && (write_addr_q == fwd_addr1);
    assign fwd_data0 = fwd_hit0 ? write_data_q : '0;
    assign fwd_data1 = fwd_hit1 ? write_data_q : '0;
`endif

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width (16 registers).
REQ-003 SHALL have parameter LQ_DEPTH, default 2, load-queue entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports alu_valid/alu_ready  input/output  1/1  ALU result handshake.
REQ-007 SHALL have ports alu_addr/alu_data  input  ADDR_W/DATA_W  ALU destination and result.
REQ-008 SHALL have ports ld_valid/ld_ready  input/output  1/1  load-result handshake.
REQ-009 SHALL have ports ld_addr/ld_data  input  ADDR_W/DATA_W  load destination and data.
REQ-010 SHALL have ports issue_valid/issue_addr  input  1/ADDR_W  decode marks destination pending.
REQ-011 SHALL have port busy  output  2**ADDR_W  per-register pending-write scoreboard.
REQ-012 SHALL have ports write_enable/write_addr/write_data  output  1/ADDR_W/DATA_W  register-file write port, registered.

Function
REQ-013 SHALL accept a transfer when valid and ready are both high at a rising edge; ready SHALL NOT depend combinationally on the same channel's valid.
REQ-014 SHALL accept loads into a FIFO of LQ_DEPTH entries; ld_ready = queue not full.
REQ-015 SHALL drive the write port from exactly one source per cycle: queue head or the ALU request.
REQ-016 SHALL give the ALU priority, except the queue head wins when the queue is full or the head has waited 2 cycles; alu_ready = 0 in those cycles.
REQ-017 SHALL, with the queue empty, accept an ALU result every cycle (alu_ready = 1).
REQ-018 SHALL present an accepted result on write_enable/addr/data exactly 1 cycle after acceptance, held for 1 cycle.
REQ-019 SHALL drive write_enable = 0 in any cycle following no acceptance.
REQ-020 SHALL accept a load into an empty queue and write it back in the same pass (1-cycle latency) when no ALU request is pending.
REQ-021 SHALL support simultaneous enqueue and dequeue with a full queue; ld_ready is computed from pre-edge occupancy.
REQ-022 SHALL set busy[issue_addr] on issue_valid and clear busy[write_addr] when that write is driven.
REQ-023 SHALL, on simultaneous set and clear of the same bit, leave it set (set wins).
REQ-024 SHALL wrap queue pointers modulo LQ_DEPTH without data loss.

Reset
REQ-025 SHALL, while rst_n = 0, force write_enable = 0, write_addr = 0, write_data = 0, busy = 0, queue empty, age counter 0, alu_ready = 1, ld_ready = 1.
REQ-026 SHALL, on reset asserted mid-transfer, discard queued and in-flight results without a write.
REQ-027 SHALL release reset synchronously to clk.

Configuration
REQ-028 SHALL honour macro WRITEBACK_FWD_EN; when defined, add inputs fwd_addr0/fwd_addr1 (ADDR_W) and outputs fwd_hit0/fwd_hit1 (1) and fwd_data0/fwd_data1 (DATA_W).
REQ-029 SHALL, with WRITEBACK_FWD_EN, assert fwd_hitN = write_enable && write_addr == fwd_addrN and drive fwd_dataN = write_data, combinationally; fwd_dataN = 0 when not hit.
REQ-030 SHALL, without WRITEBACK_FWD_EN, omit these ports entirely, with all other behaviour unchanged.

Structure
REQ-031 SHALL place DATA_W, ADDR_W defaults and typedef wb_req_t {addr, data} in shared package wb_pkg.
REQ-032 SHALL implement the load queue as sub-module wb_load_fifo (push/pop, full/empty, head, occupancy).

Verification
REQ-033 ALU-only: alu_valid=1, addr=3, data=0x5A -> next cycle write_enable=1, write_addr=3, write_data=0x5A; alu_ready stays 1.
REQ-034 Contention: ALU addr 1 every cycle plus one load addr 2 = 0xC3 -> load written no later than 3 cycles after acceptance; alu_ready=0 for exactly that cycle.
REQ-035 Full queue: 3 loads back-to-back (addr 4,5,6) with continuous ALU traffic -> ld_ready=0 after the 2nd load; all three written in order, none lost.
REQ-036 Scoreboard: issue addr 7, then in the cycle of write to 7, issue addr 7 again -> busy[7] stays 1; cleared only after the second write.
REQ-037 Reset mid-operation: 2 loads queued, rst_n=0 for 1 cycle -> no write_enable pulse, busy=0, ld_ready=1 after release.
REQ-038 With WRITEBACK_FWD_EN: write to addr 9 = 0x11 with fwd_addr0=9, fwd_addr1=8 -> fwd_hit0=1, fwd_data0=0x11, fwd_hit1=0, fwd_data1=0 in the same cycle.
